// File: rtl/io_out_pulse_pio.sv
// Avalon-MM output PIO: software-written data register with atomic set/clear,
// plus a one-shot engine that inverts selected bits for a programmed length.
module io_out_pulse_pio #(
   parameter int          WIDTH         = 4,
   parameter logic [31:0] RESET_VALUE   = 32'd0,
   parameter int          CNT_W         = 16,
   parameter logic [31:0] PULSE_DEFAULT = 32'd1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] out_r;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] cnt_r;
   logic [0:0]       state_r;
   logic             done_r;
   logic             irq_en_r;
   logic             irq_r;
   logic [31:0]      rd_r;

   logic [WIDTH-1:0] data_nxt_s;
   logic [WIDTH-1:0] mask_nxt_s;
   logic [CNT_W-1:0] len_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [0:0]       state_nxt_s;
   logic             done_nxt_s;
   logic             done_set_s;
   logic             irq_en_nxt_s;
   logic [31:0]      rd_nxt_s;

   logic             wr_s;
   logic             wr_data_s;
   logic             wr_len_s;
   logic             wr_mask_s;
   logic             wr_status_s;
   logic             wr_set_s;
   logic             wr_clr_s;
   logic [WIDTH-1:0] wmask_s;
   logic             trig_ok_s;
   logic             abort_s;
   logic             busy_s;
   logic             unused_s;

   // Status word layout shared by the read mux.
   function automatic logic [31:0] status_word(input logic ien, input logic dn, input logic bsy);
      status_word = {29'd0, ien, dn, bsy};
   endfunction

   assign wmask_s   = writedata[WIDTH-1:0];
   assign busy_s    = (state_r == ST_ACTIVE);
   assign trig_ok_s = (wmask_s != '0) && (len_r != '0);
   assign unused_s  = ^writedata;

   // Write strobe decode, one address per cycle.
   always_comb begin
      wr_s        = chipselect & ~write_n;
      wr_data_s   = 1'b0;
      wr_len_s    = 1'b0;
      wr_mask_s   = 1'b0;
      wr_status_s = 1'b0;
      wr_set_s    = 1'b0;
      wr_clr_s    = 1'b0;
      if (wr_s) begin
         case (address)
            3'd0:    wr_data_s   = 1'b1;
            3'd1:    wr_len_s    = 1'b1;
            3'd2:    wr_mask_s   = 1'b1;
            3'd3:    wr_status_s = 1'b1;
            3'd4:    wr_set_s    = 1'b1;
            3'd5:    wr_clr_s    = 1'b1;
            default: wr_data_s   = 1'b0;
         endcase
      end else begin
         wr_data_s = 1'b0;
      end
   end

   // A zero-mask write only means "abort" while a pulse is running.
   assign abort_s = (wr_status_s & writedata[0]) | (wr_mask_s & (wmask_s == '0));

   // Data and pulse-length register updates.
   always_comb begin
      data_nxt_s = data_r;
      len_nxt_s  = len_r;
      if (wr_data_s) begin
         data_nxt_s = wmask_s;
      end else if (wr_set_s) begin
         data_nxt_s = data_r | wmask_s;
      end else if (wr_clr_s) begin
         data_nxt_s = data_r & ~wmask_s;
      end else begin
         data_nxt_s = data_r;
      end
      if (wr_len_s) begin
         len_nxt_s = writedata[CNT_W-1:0];
      end else begin
         len_nxt_s = len_r;
      end
   end

   // One-shot FSM: retrigger beats abort, abort beats terminal count.
   always_comb begin
      state_nxt_s = state_r;
      mask_nxt_s  = mask_r;
      cnt_nxt_s   = cnt_r;
      done_set_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (wr_mask_s && trig_ok_s) begin
               mask_nxt_s  = wmask_s;
               cnt_nxt_s   = len_r;
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (wr_mask_s && trig_ok_s) begin
               mask_nxt_s = wmask_s;
               cnt_nxt_s  = len_r;
            end else if (abort_s) begin
               mask_nxt_s  = '0;
               cnt_nxt_s   = '0;
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == CNT_ONE) begin
               mask_nxt_s  = '0;
               cnt_nxt_s   = '0;
               done_set_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            mask_nxt_s  = '0;
            cnt_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sticky done (completion wins over W1C) and interrupt enable.
   always_comb begin
      if (done_set_s) begin
         done_nxt_s = 1'b1;
      end else if (wr_status_s && writedata[1]) begin
         done_nxt_s = 1'b0;
      end else begin
         done_nxt_s = done_r;
      end
      if (wr_status_s) begin
         irq_en_nxt_s = writedata[2];
      end else begin
         irq_en_nxt_s = irq_en_r;
      end
   end

   // Read mux, sampled every cycle regardless of chipselect.
   always_comb begin
      rd_nxt_s = 32'd0;
      case (address)
         3'd0:    rd_nxt_s[WIDTH-1:0] = data_r;
         3'd1:    rd_nxt_s[CNT_W-1:0] = len_r;
         3'd2:    rd_nxt_s[WIDTH-1:0] = mask_r;
         3'd3:    rd_nxt_s            = status_word(irq_en_r, done_r, busy_s);
         default: rd_nxt_s            = 32'd0;
      endcase
   end

   // State registers; out_port and irq are registered copies of their next values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r   <= RESET_VALUE[WIDTH-1:0];
         mask_r   <= '0;
         out_r    <= RESET_VALUE[WIDTH-1:0];
         len_r    <= PULSE_DEFAULT[CNT_W-1:0];
         cnt_r    <= '0;
         state_r  <= ST_IDLE;
         done_r   <= 1'b0;
         irq_en_r <= 1'b0;
         irq_r    <= 1'b0;
         rd_r     <= 32'd0;
      end else begin
         data_r   <= data_nxt_s;
         mask_r   <= mask_nxt_s;
         out_r    <= data_nxt_s ^ mask_nxt_s;
         len_r    <= len_nxt_s;
         cnt_r    <= cnt_nxt_s;
         state_r  <= state_nxt_s;
         done_r   <= done_nxt_s;
         irq_en_r <= irq_en_nxt_s;
         irq_r    <= done_nxt_s & irq_en_nxt_s;
         rd_r     <= rd_nxt_s;
      end
   end

   assign readdata = rd_r;
   assign out_port = out_r;
   assign irq      = irq_r;

endmodule

// File: tb/tb_io_out_pulse_pio.sv
// Scoreboard bench for io_out_pulse_pio: a cycle-indexed reference model
// pushes expectations, a negedge monitor pops and compares them.
module tb_io_out_pulse_pio;
   localparam int WIDTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;
   logic             irq;

   io_out_pulse_pio #(
      .WIDTH(WIDTH), .RESET_VALUE(32'd0), .CNT_W(CNT_W), .PULSE_DEFAULT(32'd1000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] out;
      logic             irq;
      logic [31:0]      rd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: a pulse triggered at edge c keeps its mask until edge c+len.
   logic [WIDTH-1:0] m_data;
   logic [CNT_W-1:0] m_len;
   logic [WIDTH-1:0] m_mask;
   logic             m_done;
   logic             m_irq_en;
   int               m_end;
   int               m_cyc = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_data   = '0;
      m_len    = CNT_W'(32'd1000);
      m_mask   = '0;
      m_done   = 1'b0;
      m_irq_en = 1'b0;
      m_end    = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_data);
         3'd1:    return 32'(m_len);
         3'd2:    return 32'(m_mask);
         3'd3:    return {29'd0, m_irq_en, m_done, (m_mask != '0)};
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_edge(input logic w, input logic [2:0] a, input logic [31:0] wd);
      logic             busy;
      logic             finish;
      logic [WIDTH-1:0] m;
      busy   = (m_mask != '0);
      finish = busy && (m_cyc == m_end);
      m      = wd[WIDTH-1:0];
      if (w) begin
         case (a)
            3'd0: m_data = m;
            3'd1: m_len  = wd[CNT_W-1:0];
            3'd2: begin
               if (m != '0 && m_len != '0) begin
                  m_mask = m;
                  m_end  = m_cyc + int'(m_len);
                  finish = 1'b0;
               end else if (busy && m == '0) begin
                  m_mask = '0;
                  finish = 1'b0;
               end
            end
            3'd3: begin
               if (wd[0] && busy) begin
                  m_mask = '0;
                  finish = 1'b0;
               end
               if (wd[1]) m_done = 1'b0;
               m_irq_en = wd[2];
            end
            3'd4: m_data = m_data | m;
            3'd5: m_data = m_data & ~m;
            default: ;
         endcase
      end
      if (finish) begin
         m_mask = '0;
         m_done = 1'b1;
      end
   endfunction

   task automatic step(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] wd);
      exp_t e;
      chipselect = cs;
      write_n    = ~wr;
      address    = a;
      writedata  = wd;
      e.rd = model_read(a);
      model_edge(cs & wr, a, wd);
      e.out = m_data ^ m_mask;
      e.irq = m_done & m_irq_en;
      @(posedge clk);
      sb.push_back(e);
      m_cyc++;
      #1;
   endtask

   task automatic wrt(input logic [2:0] a, input logic [31:0] wd);
      step(1'b1, 1'b1, a, wd);
   endtask

   task automatic idle(input int n, input logic [2:0] a);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 32'd0);
   endtask

   // Monitor: outputs are presented every cycle; compare one entry per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("out_port", 32'(out_port), 32'(e.out));
         check("irq", 32'(irq), 32'(e.irq));
         check("readdata", readdata, e.rd);
      end
   end

   initial begin
      logic [31:0] wd;
      logic [2:0]  a;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'd0;
      model_reset();
      #1;
      check("reset_out", 32'(out_port), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_rd", readdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset default pulse length read back.
      idle(1, 3'd1);
      check("reset_len_read", readdata, 32'd1000);

      // Set / clear.
      wrt(3'd0, 32'h5);
      check("data_write", 32'(out_port), 32'h5);
      wrt(3'd4, 32'h2);
      check("outset", 32'(out_port), 32'h7);
      wrt(3'd5, 32'h4);
      check("outclr", 32'(out_port), 32'h3);
      idle(1, 3'd0);
      check("data_read", readdata, 32'h3);

      // Pulse timing: three inverted cycles, then done and irq.
      wrt(3'd1, 32'd3);
      wrt(3'd0, 32'h1);
      wrt(3'd3, 32'h4);
      wrt(3'd2, 32'h3);
      check("pulse_c1", 32'(out_port), 32'h2);
      idle(1, 3'd3);
      check("pulse_c2", 32'(out_port), 32'h2);
      idle(1, 3'd3);
      check("pulse_c3", 32'(out_port), 32'h2);
      idle(1, 3'd3);
      check("pulse_end", 32'(out_port), 32'h1);
      idle(1, 3'd3);
      check("status_done", readdata, 32'h6);
      check("irq_done", 32'(irq), 32'd1);
      wrt(3'd3, 32'h6);
      check("irq_clear", 32'(irq), 32'd0);

      // Retrigger after 4 cycles, then a separate abort run.
      wrt(3'd1, 32'd10);
      wrt(3'd2, 32'h1);
      idle(3, 3'd3);
      wrt(3'd2, 32'h8);
      idle(11, 3'd3);
      wrt(3'd2, 32'h2);
      idle(2, 3'd3);
      wrt(3'd3, 32'h5);
      check("abort_restore", 32'(out_port), 32'h1);
      idle(2, 3'd3);

      // Degenerate triggers in idle.
      wrt(3'd2, 32'h0);
      wrt(3'd1, 32'h0);
      wrt(3'd2, 32'h5);
      idle(2, 3'd3);
      wrt(3'd6, 32'hFFFF_FFFF);
      idle(1, 3'd7);

      // Reset mid-pulse.
      wrt(3'd0, 32'h0);
      wrt(3'd1, 32'd20);
      wrt(3'd2, 32'hF);
      idle(3, 3'd2);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_out", 32'(out_port), 32'd0);
      check("async_reset_irq", 32'(irq), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(2, 3'd3);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         a  = 3'($urandom_range(0, 7));
         wd = $urandom();
         if (a == 3'd1) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
         if (a == 3'd2 && $urandom_range(0, 4) == 0) wd = wd & 32'hFFFF_FFF0;
         case ($urandom_range(0, 9))
            0, 1, 2, 3:    step(1'b0, 1'b0, a, wd);
            4:             step(1'b0, 1'b1, a, wd);
            default:       step(1'b1, 1'b1, a, wd);
         endcase
      end

      idle(2, 3'd0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/io_out_pulse_pio.md
Name: io_out_pulse_pio

Overview:
Avalon-MM slave output port, the transmit-side counterpart of the button input PIO. It drives WIDTH output pins (LEDs, enables, motor-ctrl strobes) from a software-written data register. Atomic set/clear addresses avoid read-modify-write from software. A hardware one-shot engine inverts selected bits for a programmed number of clk cycles, then restores them and raises a sticky done flag and an optional irq.

Parameters:
WIDTH, 4, number of output bits (1..32)
RESET_VALUE, 0, data_reg value at reset
CNT_W, 16, pulse length counter width (1..32)
PULSE_DEFAULT, 1000, pulse_len value at reset

Ports:
clk  input  1  system clock
reset_n  input  1  reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  write strobe, active-low
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  WIDTH  output pins
irq  output  1  pulse-done interrupt, level, active-high

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All state is on rising clk.
- Reset values: data_reg=RESET_VALUE, pulse_len=PULSE_DEFAULT, active_mask=0, cnt=0, state=IDLE, done=0, irq_en=0, readdata=0. So out_port=RESET_VALUE and irq=0.
- wr = chipselect & ~write_n. Exactly one address is written per cycle.
- Address map:
  - 0 DATA, rw: data_reg <= writedata[WIDTH-1:0].
  - 1 PULSE_LEN, rw: pulse_len <= writedata[CNT_W-1:0].
  - 2 PULSE_MASK: write starts or retriggers a pulse. Read returns active_mask.
  - 3 STATUS: read {29'b0, irq_en, done, busy}. Write: bit0=1 aborts the pulse; bit1=1 clears done (W1C); bit2 loads irq_en.
  - 4 OUTSET, write-only: data_reg <= data_reg | writedata.
  - 5 OUTCLR, write-only: data_reg <= data_reg & ~writedata.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- Reads:
  - readdata is registered and updates every clk from the current address, independent of chipselect. Fixed 1-cycle read latency.
  - Unused upper bits read 0. OUTSET and OUTCLR read 0.
- out_port = data_reg XOR active_mask, built from registers only. A write captured at edge N is visible on out_port after edge N.
- Pulse FSM, states IDLE and ACTIVE; busy = (state==ACTIVE):
  - IDLE, PULSE_MASK write with m = writedata[WIDTH-1:0] != 0 and pulse_len != 0: active_mask<=m, cnt<=pulse_len, go to ACTIVE.
  - IDLE, m==0 or pulse_len==0: the write is ignored. No state change, done unchanged.
  - ACTIVE, cnt>1: cnt<=cnt-1.
  - ACTIVE, cnt==1: active_mask<=0, cnt<=0, done<=1, go to IDLE. Bits are inverted for exactly pulse_len cycles.
  - ACTIVE, PULSE_MASK write with m!=0 and pulse_len!=0 (retrigger): active_mask<=m, cnt<=pulse_len. This takes precedence over the terminal decrement, and done is not set.
  - ACTIVE, PULSE_MASK write with m==0: treated as an abort.
  - ACTIVE, abort (STATUS bit0 write, or zero-mask write): active_mask<=0, cnt<=0, go to IDLE. done is not set.
- done:
  - Set only on natural completion.
  - If a W1C clear and a completion land on the same edge, set wins.
- irq = done & irq_en, registered-output equivalent (derived from registers).
- PULSE_LEN writes during ACTIVE affect only the next trigger; the running cnt is unchanged.
- DATA, OUTSET and OUTCLR writes during ACTIVE update data_reg immediately. out_port shows new data_reg XOR active_mask; when the pulse ends the bits settle to the new data_reg.
- Reset asserted mid-pulse returns everything to reset values immediately (asynchronously). No done or irq results.

Test Plan:
- Reset: reset_n low with RESET_VALUE=0 -> out_port=0, irq=0; reading addr 1 gives readdata=1000 one cycle after address.
- Set/clear: write DATA=0x5, then OUTSET=0x2, then OUTCLR=0x4 -> out_port goes 0x5, 0x7, 0x3; DATA readback 0x3.
- Pulse timing:
  - Step 1: pulse_len=3, DATA=0x1, irq_en=1, then write PULSE_MASK=0x3.
  - Step 2: out_port=0x2 for exactly 3 cycles, then 0x1.
  - Step 3: STATUS reads 0x6 and irq=1; writing STATUS=0x2 -> irq=0.
- Retrigger/abort:
  - Retrigger: pulse_len=10, mask 0x1, rewrite mask 0x8 after 4 cycles -> 0x8 inverted for 10 more cycles, done=0 until end.
  - Abort: a separate run with a STATUS bit0 write mid-pulse -> out_port restored next cycle, done stays 0.
- Degenerate: pulse_len=0 or mask=0 written in IDLE -> busy stays 0, out_port unchanged, done unchanged.
- Reset mid-pulse: assert reset_n during ACTIVE -> out_port=RESET_VALUE immediately; after release, busy=0, done=0.
